spi_slave_gen2: RTL and testbench
=================================

SPI_SLAVE_GEN2 -- requirements
Module: spi_slave_gen2

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, payload bits per frame; legal range 2..32.
REQ-002 The block SHALL have parameter LSB_FIRST, default 0, MISO bit order: 0 = MSB first, 1 = LSB first.
REQ-003 The block SHALL have localparam FRAME_W = DATA_W+2, the received frame length (2 command bits plus payload).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  single clock; all sampling on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in.
- tx_data  in  DATA_W  read data to return.
- tx_valid  in  1  tx_data valid.
- MISO  out  1  serial data out.
- rx_data  out  FRAME_W  received frame.
- rx_valid  out  1  one-cycle frame-complete pulse.
- frame_err  out  1  one-cycle abort pulse.
- tx_busy  out  1  MISO shift in progress.

Function
REQ-005 The FSM SHALL have the states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-006 In IDLE, the FSM SHALL go to CHK_CMD when SS_n=0, and otherwise stay in IDLE.
REQ-007 From CHK_CMD, the next state SHALL be determined as follows:
- SS_n=1 -> IDLE.
- MOSI=0 -> WRITE.
- MOSI=1 and rd_addr_flag=0 -> READ_ADD.
- MOSI=1 and rd_addr_flag=1 -> READ_DATA.
REQ-008 The CHK_CMD MOSI bit SHALL be a direction bit only and SHALL NOT be stored.
REQ-009 In WRITE, READ_ADD and READ_DATA, the FSM SHALL go to IDLE when SS_n=1, and otherwise hold.
REQ-010 In the data states, MOSI SHALL be shifted into the frame register MSB-first, one bit per clock, with counter rx_cnt running from 0 to FRAME_W.
REQ-011 The cycle after the FRAME_W-th bit is sampled, rx_data SHALL load the frame and rx_valid SHALL be 1 for exactly one clock.
REQ-012 rx_data SHALL hold its value until the next completed frame.
REQ-013 Bits arriving after frame completion in the same SS_n-low window SHALL be ignored; there SHALL be no second rx_valid in that window.
REQ-014 Completion of a READ_ADD frame SHALL set rd_addr_flag.
REQ-015 Completion of a READ_DATA frame SHALL clear rd_addr_flag.
REQ-016 An aborted frame SHALL leave rd_addr_flag unchanged.
REQ-017 After READ_DATA frame completion, the block SHALL be armed; the first rising edge with tx_valid=1 while armed and SS_n=0 SHALL capture tx_data and clear the armed state.
REQ-018 Starting the cycle after tx_data capture, MISO SHALL present the captured bits for DATA_W consecutive cycles, in the order set by LSB_FIRST, with tx_busy=1 for those cycles.
REQ-019 MISO SHALL be 0 whenever no shift is in progress.
REQ-020 tx_valid SHALL be ignored when the block is not armed, including during a shift.
REQ-021 SS_n rising while 0 < rx_cnt < FRAME_W SHALL pulse frame_err for one clock, suppress rx_valid and return the FSM to IDLE.
REQ-022 SS_n rising during a MISO shift SHALL abort the shift: MISO=0 and tx_busy=0 next cycle, armed state cleared, no frame_err.
REQ-023 SS_n rising in CHK_CMD SHALL NOT assert frame_err.
REQ-024 On re-entry to CHK_CMD, rx_cnt SHALL clear to 0.
REQ-025 If frame completion and SS_n rising occur on the same edge, rx_valid SHALL win and frame_err SHALL stay 0.

Reset
REQ-026 While rst=1, the outputs and state SHALL hold these values: cs=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, tx_busy=0, rd_addr_flag=0, armed=0, rx_cnt=0.
REQ-027 Reset SHALL take effect immediately, independent of clk.
REQ-028 Normal operation SHALL resume on the first rising edge after rst falls.
REQ-029 Reset mid-frame or mid-shift SHALL discard all partial data, with no rx_valid or frame_err pulse.

Verification
REQ-030 The bench SHALL cover the following directed scenarios at DATA_W=8:
- Write frame: SS_n=0; CHK_CMD MOSI=0; frame bits 00_1010_0101 -> one-cycle rx_valid, rx_data=10'h0A5, cs=WRITE until SS_n=1.
- Read sequence: READ_ADD frame 10_0011_1100 -> rx_data=10'h23C, rd_addr_flag=1; next select CHK_CMD MOSI=1 -> READ_DATA; frame 11_0000_0000; tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 over 8 cycles with tx_busy=1, then MISO=0 and rd_addr_flag=0.
- LSB_FIRST=1: same read sequence with tx_data=8'hA0 -> MISO 0,0,0,0,0,1,0,1.
- Abort: SS_n=1 after 4 data bits in WRITE -> frame_err one cycle, rx_valid stays 0, cs=IDLE, rx_data unchanged.
- Read without address: rd_addr_flag=0, CHK_CMD MOSI=1 -> READ_ADD, not READ_DATA.
- Reset mid-frame: rst=1 at data bit 5 -> cs=IDLE, rx_data=0, MISO=0 immediately; frame restarted after reset completes normally.

Source files
------------

// File: rtl/spi_slave_gen2.sv
// spi_slave_gen2: clock-sampled SPI slave. A direction bit selects a write
// frame or a two-step read (address frame, then data frame); completing the
// data frame arms a MISO shift of the next accepted tx_data word.
module spi_slave_gen2 #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int FRAME_W  = DATA_W + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               tx_busy
);

  localparam int RX_CW = $clog2(FRAME_W + 1);
  localparam int TX_CW = $clog2(DATA_W + 1);

  localparam logic [RX_CW-1:0] RX_ONE  = RX_CW'(1);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(FRAME_W);
  localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(FRAME_W - 1);
  localparam logic [TX_CW-1:0] TX_ONE  = TX_CW'(1);
  localparam logic [TX_CW-1:0] TX_LAST = TX_CW'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t             cs;
  logic [RX_CW-1:0]   rx_cnt;
  logic [FRAME_W-2:0] rx_shreg;
  logic               rd_addr_flag;
  logic               armed;
  logic [DATA_W-1:0]  tx_shreg;
  logic [TX_CW-1:0]   tx_cnt;
  logic               rd_data_done;

  // Last payload bit of a READ_DATA frame is being sampled on this edge.
  assign rd_data_done = (cs == READ_DATA) && !SS_n && (rx_cnt == RX_LAST);

  // Command decode, frame reception, abort detection and read-address flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs           <= IDLE;
      rx_cnt       <= '0;
      rx_shreg     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_flag <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (cs)
        IDLE: begin
          if (!SS_n) begin
            cs     <= CHK_CMD;
            rx_cnt <= '0;
          end
        end
        CHK_CMD: begin
          rx_cnt <= '0;
          if (SS_n)
            cs <= IDLE;
          else if (!MOSI)
            cs <= WRITE;
          else if (rd_addr_flag)
            cs <= READ_DATA;
          else
            cs <= READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (SS_n) begin
            cs <= IDLE;
            // A completed frame (rx_cnt == FRAME_W) never reports an abort.
            if ((rx_cnt != '0) && (rx_cnt < RX_FULL))
              frame_err <= 1'b1;
          end else if (rx_cnt < RX_FULL) begin
            rx_shreg <= {rx_shreg[FRAME_W-3:0], MOSI};
            rx_cnt   <= rx_cnt + RX_ONE;
            // The final bit goes straight into rx_data so rx_valid lands
            // on the cycle right after it is sampled.
            if (rx_cnt == RX_LAST) begin
              rx_data  <= {rx_shreg, MOSI};
              rx_valid <= 1'b1;
              if (cs == READ_ADD)
                rd_addr_flag <= 1'b1;
              else if (cs == READ_DATA)
                rd_addr_flag <= 1'b0;
            end
          end
        end
        default: cs <= IDLE;
      endcase
    end
  end

  // Arming after a read-data frame, tx_data capture and MISO shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      tx_busy  <= 1'b0;
      MISO     <= 1'b0;
      tx_shreg <= '0;
      tx_cnt   <= '0;
    end else begin
      if (tx_busy) begin
        if (SS_n) begin
          tx_busy <= 1'b0;
          MISO    <= 1'b0;
          armed   <= 1'b0;
        end else if (tx_cnt == TX_LAST) begin
          tx_busy <= 1'b0;
          MISO    <= 1'b0;
        end else begin
          MISO     <= LSB_FIRST ? tx_shreg[0] : tx_shreg[DATA_W-1];
          tx_shreg <= LSB_FIRST ? (tx_shreg >> 1) : (tx_shreg << 1);
          tx_cnt   <= tx_cnt + TX_ONE;
        end
      end else if (armed && tx_valid && !SS_n) begin
        // First bit is driven from the capture edge itself.
        armed    <= 1'b0;
        tx_busy  <= 1'b1;
        MISO     <= LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
        tx_shreg <= LSB_FIRST ? (tx_data >> 1) : (tx_data << 1);
        tx_cnt   <= TX_ONE;
      end
      if (rd_data_done)
        armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Scoreboard bench for spi_slave_gen2: two instances (MSB-first and
// LSB-first) share stimulus; a transaction-level model pushes expected
// frames, aborts and MISO words; a negedge monitor pops and compares.
module tb_spi_slave_gen2;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               ss_n;
  logic               mosi;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  logic               miso0, miso1;
  logic [FRAME_W-1:0] rx_data0, rx_data1;
  logic               rx_valid0, rx_valid1;
  logic               frame_err0, frame_err1;
  logic               tx_busy0, tx_busy1;

  spi_slave_gen2 #(.DATA_W(DATA_W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .MISO(miso0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .frame_err(frame_err0), .tx_busy(tx_busy0)
  );

  spi_slave_gen2 #(.DATA_W(DATA_W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .MISO(miso1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .frame_err(frame_err1), .tx_busy(tx_busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                nbits;
  } tx_exp_t;

  logic [FRAME_W-1:0] exp_rx[$];
  int                 exp_err[$];
  tx_exp_t            exp_tx[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: read-address flag, armed, last good frame.
  bit                 m_flag = 1'b0;
  bit                 m_armed = 1'b0;
  logic [FRAME_W-1:0] m_last_rx = '0;

  logic [DATA_W-1:0] col0, col1;
  int                cnt0, cnt1;

  function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever either DUT presents an output event.
  always @(negedge clk) begin
    if (rst) begin
      cnt0 = 0; cnt1 = 0; col0 = '0; col1 = '0;
    end else begin
      if (rx_valid0 || rx_valid1) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: rx_valid=%b/%b rx_data=%h/%h required no frame",
                   rx_valid0, rx_valid1, rx_data0, rx_data1);
        end else begin
          logic [FRAME_W-1:0] e;
          e = exp_rx.pop_front();
          if (!(rx_valid0 && rx_valid1 && rx_data0 === e && rx_data1 === e)) begin
            errors++;
            $display("FAIL rx_frame: rx_valid=%b/%b rx_data=%h/%h required %h",
                     rx_valid0, rx_valid1, rx_data0, rx_data1, e);
          end
        end
      end
      if (frame_err0 || frame_err1) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("FAIL frame_err_unexpected: frame_err=%b/%b required 0/0", frame_err0, frame_err1);
        end else begin
          void'(exp_err.pop_front());
          if (!(frame_err0 && frame_err1 && !rx_valid0 && !rx_valid1)) begin
            errors++;
            $display("FAIL frame_err: frame_err=%b/%b rx_valid=%b/%b required 1/1 0/0",
                     frame_err0, frame_err1, rx_valid0, rx_valid1);
          end
        end
      end
      if (tx_busy0) begin col0 = {col0[DATA_W-2:0], miso0}; cnt0++; end
      if (tx_busy1) begin col1 = {col1[DATA_W-2:0], miso1}; cnt1++; end
      if (!tx_busy0 && !tx_busy1 && (cnt0 != 0 || cnt1 != 0)) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: shifted %0d/%0d bits %h/%h required no shift",
                   cnt0, cnt1, col0, col1);
        end else begin
          tx_exp_t e;
          logic [DATA_W-1:0] w0, w1;
          e  = exp_tx.pop_front();
          w0 = e.data >> (DATA_W - e.nbits);
          w1 = rev(e.data) >> (DATA_W - e.nbits);
          if (cnt0 != e.nbits || cnt1 != e.nbits || col0 !== w0 || col1 !== w1) begin
            errors++;
            $display("FAIL tx_shift: bits=%0d/%0d word=%h/%h required bits=%0d word=%h/%h",
                     cnt0, cnt1, col0, col1, e.nbits, w0, w1);
          end
        end
        cnt0 = 0; cnt1 = 0; col0 = '0; col1 = '0;
      end
      if (!tx_busy0 || !tx_busy1) begin
        checks++;
        if ((!tx_busy0 && miso0) || (!tx_busy1 && miso1)) begin
          errors++;
          $display("FAIL miso_idle: miso=%b/%b busy=%b/%b required miso 0 when idle",
                   miso0, miso1, tx_busy0, tx_busy1);
        end
      end
    end
  end

  // One select window. n<0: abort in CHK_CMD; n=bits sent after the
  // direction bit. Read frames are followed by a tx_valid pulse with txd;
  // tx_bits<DATA_W raises SS_n after that many MISO bits.
  task automatic run_frame(input bit cmd, input logic [FRAME_W-1:0] bits, input int n,
                           input logic [DATA_W-1:0] txd, input int tx_bits);
    int kind;
    int nt;
    ss_n = 1'b0; mosi = 1'($urandom); tick;
    if (n < 0) begin
      ss_n = 1'b1; tick;
      return;
    end
    mosi = cmd; tick;
    kind = !cmd ? 0 : (m_flag ? 2 : 1);
    for (int i = 0; i < n; i++) begin
      if (i < FRAME_W) begin
        mosi = bits[FRAME_W-1-i]; tx_valid = 1'($urandom);
      end else begin
        mosi = 1'($urandom); tx_valid = 1'b0;
      end
      tx_data = DATA_W'($urandom);
      tick;
      if (i == FRAME_W - 1) begin
        exp_rx.push_back(bits);
        m_last_rx = bits;
        if (kind == 1) m_flag = 1'b1;
        if (kind == 2) begin m_flag = 1'b0; m_armed = 1'b1; end
      end
    end
    tx_valid = 1'b0;
    if (n > 0 && n < FRAME_W) exp_err.push_back(n);
    if (cmd && n >= FRAME_W) begin
      repeat ($urandom_range(0, 2)) tick;
      tx_valid = 1'b1; tx_data = txd; tick;
      tx_valid = 1'b0;
      if (m_armed) begin
        m_armed = 1'b0;
        exp_tx.push_back(tx_exp_t'{data: txd, nbits: tx_bits});
      end
      nt = (tx_bits == DATA_W) ? DATA_W : tx_bits - 1;
      for (int j = 0; j < nt; j++) begin
        tx_valid = 1'($urandom); tx_data = DATA_W'($urandom); tick;
      end
      tx_valid = 1'b0;
    end
    ss_n = 1'b1; tick;
    repeat ($urandom_range(0, 2)) tick;
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
    #12;
    check("reset_rx_data", 32'({rx_data0, rx_data1}), 32'h0);
    check("reset_pulses", 32'({rx_valid0, rx_valid1, frame_err0, frame_err1}), 32'h0);
    check("reset_miso_busy", 32'({miso0, miso1, tx_busy0, tx_busy1}), 32'h0);
    tick;
    rst = 1'b0;
    tick;

    run_frame(1'b0, 10'h0A5, FRAME_W, 8'h00, DATA_W);   // write
    run_frame(1'b1, 10'h23C, FRAME_W, 8'h5A, DATA_W);   // read address
    run_frame(1'b1, 10'h300, FRAME_W, 8'hC3, DATA_W);   // read data
    run_frame(1'b1, 10'h23C, FRAME_W, 8'h11, DATA_W);   // read without address
    run_frame(1'b1, 10'h300, FRAME_W, 8'hA0, DATA_W);
    run_frame(1'b0, 10'h155, 4, 8'h00, DATA_W);         // abort after 4 bits
    check("abort_rx_hold", 32'({rx_data0, rx_data1}), 32'({m_last_rx, m_last_rx}));
    run_frame(1'b1, 10'h0F0, FRAME_W, 8'h00, DATA_W);
    run_frame(1'b1, 10'h3FF, FRAME_W, 8'h96, 3);        // shift aborted by SS_n
    run_frame(1'b0, 10'h2AA, -1, 8'h00, DATA_W);        // abort in CHK_CMD
    run_frame(1'b0, 10'h2AA, 0, 8'h00, DATA_W);         // abort with no data bits
    run_frame(1'b0, 10'h1E3, FRAME_W + 3, 8'h00, DATA_W); // trailing bits ignored
    run_frame(1'b1, 10'h111, FRAME_W, 8'h00, DATA_W);   // set address flag

    // Reset mid-frame at data bit 5, asserted between clock edges.
    ss_n = 1'b0; tick;
    mosi = 1'b0; tick;
    for (int i = 0; i < 5; i++) begin mosi = 1'($urandom); tick; end
    #2 rst = 1'b1;
    #1;
    check("midrst_rx_data", 32'({rx_data0, rx_data1}), 32'h0);
    check("midrst_miso_busy", 32'({miso0, miso1, tx_busy0, tx_busy1}), 32'h0);
    check("midrst_pulses", 32'({rx_valid0, rx_valid1, frame_err0, frame_err1}), 32'h0);
    m_flag = 1'b0; m_armed = 1'b0; m_last_rx = '0;
    ss_n = 1'b1; tick; tick;
    #2 rst = 1'b0;
    run_frame(1'b1, 10'h2C7, FRAME_W, 8'h3C, DATA_W);   // address again after reset
    run_frame(1'b1, 10'h301, FRAME_W, 8'h5E, DATA_W);
    run_frame(1'b0, 10'h0A5, FRAME_W, 8'h00, DATA_W);

    for (int k = 0; k < 60; k++) begin
      int r, n, tb_bits;
      r = $urandom_range(0, 9);
      n = (r == 0) ? -1 : (r == 1) ? 0 : (r == 2) ? int'($urandom_range(1, FRAME_W - 1)) :
          (r == 3) ? int'($urandom_range(FRAME_W + 1, FRAME_W + 3)) : FRAME_W;
      tb_bits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DATA_W - 1)) : DATA_W;
      run_frame(1'($urandom_range(0, 2) != 0), FRAME_W'($urandom), n, DATA_W'($urandom), tb_bits);
    end

    repeat (3) tick;
    check("left_rx", 32'(exp_rx.size()), 32'h0);
    check("left_err", 32'(exp_err.size()), 32'h0);
    check("left_tx", 32'(exp_tx.size()), 32'h0);
    check("left_shift_bits", 32'(cnt0 + cnt1), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
